cndm_proto_irq_ctrl: RTL and testbench

- Sits directly downstream of the core's per-port irq outputs.
- Turns per-port interrupt events into a single serialized interrupt-message request stream (index + valid/ready) for the PCIe MSI/MSI-X generator.
- Per port it provides a pending latch, enable masking and a hold-off (moderation) timer.
- A round-robin arbiter chooses among ports that are ready to issue.

---
 rtl/cndm_proto_irq_ctrl.sv | 116 +++++++++++
 tb/tb_cndm_proto_irq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cndm_proto_irq_ctrl.sv
// Per-port interrupt pending/mask/hold-off with round-robin selection, feeding
// a single valid/ready vector-index request stream toward the MSI generator.
module cndm_proto_irq_ctrl #(
   parameter int PORTS       = 2,
   parameter int IRQ_INDEX_W = 5,
   parameter int IRQ_BASE    = 0,
   parameter int TIMER_W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PORTS-1:0]       irq_in,
   input  logic [PORTS-1:0]       cfg_enable,
   input  logic [TIMER_W-1:0]     cfg_holdoff,
   output logic [IRQ_INDEX_W-1:0] m_irq_index,
   output logic                   m_irq_valid,
   input  logic                   m_irq_ready,
   output logic [PORTS-1:0]       sts_pending
);

   // state | meaning
   // IDLE  | no request outstanding; arbitrate among eligible ports
   // REQ   | request for port ptr presented, waiting for m_irq_ready

   localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

   if (IRQ_BASE + PORTS - 1 >= (1 << IRQ_INDEX_W)) begin : g_index_range
      $error("IRQ_BASE + PORTS - 1 does not fit in IRQ_INDEX_W bits");
   end

   typedef enum logic {ST_IDLE, ST_REQ} state_t;

   state_t                 state, state_nxt;
   logic [PORTS-1:0]       pending, pending_nxt, eligible;
   logic [TIMER_W-1:0]     timer     [PORTS];
   logic [TIMER_W-1:0]     timer_nxt [PORTS];
   logic [PTR_W-1:0]       ptr, ptr_nxt, pick;
   logic [IRQ_INDEX_W-1:0] index_q, index_nxt;
   logic                   accept, found;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         pending <= '0;
         ptr     <= PTR_W'(PORTS - 1);
         index_q <= '0;
         for (int p = 0; p < PORTS; p++) timer[p] <= '0;
      end else begin
         state   <= state_nxt;
         pending <= pending_nxt;
         ptr     <= ptr_nxt;
         index_q <= index_nxt;
         for (int p = 0; p < PORTS; p++) timer[p] <= timer_nxt[p];
      end
   end

   // While in REQ, ptr names the port whose request is on the output.
   assign accept = (state == ST_REQ) && m_irq_ready;

   always_comb begin
      for (int p = 0; p < PORTS; p++) begin
         eligible[p] = pending[p] && cfg_enable[p] && (timer[p] == '0) &&
                       !((state == ST_REQ) && (index_q == IRQ_INDEX_W'(IRQ_BASE + p)));
         pending_nxt[p] = irq_in[p] || (pending[p] && !(accept && (ptr == PTR_W'(p))));
         if (accept && (ptr == PTR_W'(p)))
            timer_nxt[p] = cfg_holdoff;
         else if (timer[p] != '0)
            timer_nxt[p] = timer[p] - TIMER_W'(1);
         else
            timer_nxt[p] = timer[p];
      end
   end

   // Round-robin scan: ports above ptr first, then wrap to ptr and below.
   always_comb begin
      found = 1'b0;
      pick  = ptr;
      for (int c = 0; c < PORTS; c++) begin
         if (!found && (c > int'(ptr)) && eligible[c]) begin
            found = 1'b1;
            pick  = PTR_W'(c);
         end
      end
      for (int c = 0; c < PORTS; c++) begin
         if (!found && (c <= int'(ptr)) && eligible[c]) begin
            found = 1'b1;
            pick  = PTR_W'(c);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      index_nxt = index_q;
      case (state)
         ST_IDLE: begin
            if (found) begin
               state_nxt = ST_REQ;
               ptr_nxt   = pick;
               index_nxt = IRQ_INDEX_W'(IRQ_BASE) + IRQ_INDEX_W'(pick);
            end
         end
         ST_REQ: begin
            if (m_irq_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      m_irq_valid = (state == ST_REQ);
      m_irq_index = index_q;
      sts_pending = pending;
   end

endmodule

// File: tb/tb_cndm_proto_irq_ctrl.sv
// Directed bench for cndm_proto_irq_ctrl: a 2-port build at IRQ_BASE=4 and a
// 4-port build at IRQ_BASE=0 for round-robin ordering.
module tb_cndm_proto_irq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  irq_in, cfg_enable, sts_pending;
   logic [15:0] cfg_holdoff;
   logic [4:0]  m_irq_index;
   logic        m_irq_valid, m_irq_ready;

   logic [3:0]  irq_b, en_b, pend_b;
   logic [15:0] hold_b;
   logic [4:0]  idx_b;
   logic        valid_b, ready_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cndm_proto_irq_ctrl #(.PORTS(2), .IRQ_INDEX_W(5), .IRQ_BASE(4), .TIMER_W(16)) dut (
      .clk(clk), .rst(rst), .irq_in(irq_in), .cfg_enable(cfg_enable),
      .cfg_holdoff(cfg_holdoff), .m_irq_index(m_irq_index), .m_irq_valid(m_irq_valid),
      .m_irq_ready(m_irq_ready), .sts_pending(sts_pending)
   );

   cndm_proto_irq_ctrl #(.PORTS(4), .IRQ_INDEX_W(5), .IRQ_BASE(0), .TIMER_W(16)) dut4 (
      .clk(clk), .rst(rst), .irq_in(irq_b), .cfg_enable(en_b),
      .cfg_holdoff(hold_b), .m_irq_index(idx_b), .m_irq_valid(valid_b),
      .m_irq_ready(ready_b), .sts_pending(pend_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (m_irq_valid === 1'b1) begin
            ok = 1'b1;
            return;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; irq_in = '0; cfg_enable = '0; cfg_holdoff = '0; m_irq_ready = 1'b0;
      irq_b = '0; en_b = 4'b1111; hold_b = '0; ready_b = 1'b1;
      tick(); tick();
      checks++;
      if (m_irq_valid !== 1'b0 || m_irq_index !== 5'd0 || sts_pending !== 2'b00 ||
          valid_b !== 1'b0 || pend_b !== 4'b0000) begin
         errors++;
         $display("FAIL reset_state valid=%b index=%0d pending=%b (required 0 0 00)",
                  m_irq_valid, m_irq_index, sts_pending);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      cfg_enable = 2'b11; cfg_holdoff = '0; m_irq_ready = 1'b1;
      irq_in = 2'b10; tick(); irq_in = '0;
      checks++;
      if (sts_pending !== 2'b10 || m_irq_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_latch pending=%b valid=%b (required 10 0)", sts_pending, m_irq_valid);
      end
      tick();
      checks++;
      if (m_irq_valid !== 1'b1 || m_irq_index !== 5'd5) begin
         errors++;
         $display("FAIL single_issue valid=%b index=%0d (required 1 5)", m_irq_valid, m_irq_index);
      end
      tick();
      checks++;
      if (m_irq_valid !== 1'b0 || sts_pending !== 2'b00) begin
         errors++;
         $display("FAIL single_clear valid=%b pending=%b (required 0 00)", m_irq_valid, sts_pending);
      end
   endtask

   task automatic test_merge();
      int bad = 0;
      int seen = 0;
      m_irq_ready = 1'b0;
      irq_in = 2'b01; tick(); irq_in = '0; tick();
      checks++;
      if (m_irq_valid !== 1'b1 || m_irq_index !== 5'd4) begin
         errors++;
         $display("FAIL merge_issue valid=%b index=%0d (required 1 4)", m_irq_valid, m_irq_index);
      end
      for (int k = 0; k < 8; k++) begin
         irq_in = (k % 3 == 0) ? 2'b01 : 2'b00;
         tick();
         if (m_irq_valid !== 1'b1 || m_irq_index !== 5'd4) bad++;
      end
      irq_in = '0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL merge_hold unstable_cycles=%0d (required 0)", bad);
      end
      m_irq_ready = 1'b1;
      tick();
      checks++;
      if (m_irq_valid !== 1'b0 || sts_pending !== 2'b00) begin
         errors++;
         $display("FAIL merge_accept valid=%b pending=%b (required 0 00)", m_irq_valid, sts_pending);
      end
      for (int k = 0; k < 10; k++) begin
         tick();
         if (m_irq_valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL merge_no_repeat requests=%0d (required 0)", seen);
      end
   endtask

   task automatic test_set_wins();
      m_irq_ready = 1'b0;
      irq_in = 2'b01; tick(); irq_in = '0; tick();
      m_irq_ready = 1'b1; irq_in = 2'b01;
      tick();
      irq_in = '0;
      checks++;
      if (m_irq_valid !== 1'b0 || sts_pending[0] !== 1'b1) begin
         errors++;
         $display("FAIL setwins_latch valid=%b pending0=%b (required 0 1)", m_irq_valid, sts_pending[0]);
      end
      tick();
      checks++;
      if (m_irq_valid !== 1'b1 || m_irq_index !== 5'd4) begin
         errors++;
         $display("FAIL setwins_reissue valid=%b index=%0d (required 1 4)", m_irq_valid, m_irq_index);
      end
      tick();
      checks++;
      if (m_irq_valid !== 1'b0 || sts_pending !== 2'b00) begin
         errors++;
         $display("FAIL setwins_clear valid=%b pending=%b (required 0 00)", m_irq_valid, sts_pending);
      end
   endtask

   task automatic test_holdoff();
      bit ok;
      int gap;
      int pend_bad = 0;
      cfg_holdoff = 16'd20; m_irq_ready = 1'b1; irq_in = 2'b01;
      wait_valid(10, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL hold_first valid=%b after 10 cycles (required 1)", m_irq_valid);
      end
      for (int r = 0; r < 2; r++) begin
         tick();
         gap = 0;
         while (m_irq_valid !== 1'b1 && gap < 100) begin
            if (sts_pending[0] !== 1'b1) pend_bad++;
            gap++;
            tick();
         end
         if (r == 1) irq_in = '0;
         checks++;
         if (gap != 21 || m_irq_index !== 5'd4) begin
            errors++;
            $display("FAIL hold_gap round=%0d idle_cycles=%0d index=%0d (required 21 4)",
                     r, gap, m_irq_index);
         end
      end
      checks++;
      if (pend_bad != 0) begin
         errors++;
         $display("FAIL hold_pending cleared_cycles=%0d (required 0)", pend_bad);
      end
      cfg_holdoff = '0;
      for (int k = 0; k < 40; k++) tick();
      checks++;
      if (m_irq_valid !== 1'b0 || sts_pending !== 2'b00) begin
         errors++;
         $display("FAIL hold_drain valid=%b pending=%b (required 0 00)", m_irq_valid, sts_pending);
      end
   endtask

   task automatic test_round_robin();
      int q[$];
      rst = 1'b1; tick(); rst = 1'b0; tick();
      cfg_enable = 2'b11; cfg_holdoff = '0; m_irq_ready = 1'b1;
      for (int rep = 0; rep < 2; rep++) begin
         q.delete();
         irq_in = 2'b11; tick(); irq_in = '0;
         for (int k = 0; k < 8; k++) begin
            tick();
            if (m_irq_valid === 1'b1) q.push_back(int'(m_irq_index));
         end
         checks++;
         if (q.size() != 2 || q[0] != 4 || q[1] != 5) begin
            errors++;
            $display("FAIL rr_two_port rep=%0d count=%0d first=%0d second=%0d (required 2 4 5)",
                     rep, q.size(), (q.size() > 0) ? q[0] : -1, (q.size() > 1) ? q[1] : -1);
         end
      end
      q.delete();
      irq_b = 4'b1111; tick(); irq_b = '0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (valid_b === 1'b1) q.push_back(int'(idx_b));
      end
      checks++;
      if (q.size() != 4 || q[0] != 0 || q[1] != 1 || q[2] != 2 || q[3] != 3) begin
         errors++;
         $display("FAIL rr_four_port count=%0d order=%0d,%0d,%0d,%0d (required 4 0,1,2,3)",
                  q.size(), (q.size() > 0) ? q[0] : -1, (q.size() > 1) ? q[1] : -1,
                  (q.size() > 2) ? q[2] : -1, (q.size() > 3) ? q[3] : -1);
      end
   endtask

   task automatic test_masking();
      int bad = 0;
      cfg_enable = 2'b10; m_irq_ready = 1'b1;
      irq_in = 2'b01; tick(); irq_in = '0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (m_irq_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0 || sts_pending[0] !== 1'b1) begin
         errors++;
         $display("FAIL mask_hold requests=%0d pending0=%b (required 0 1)", bad, sts_pending[0]);
      end
      cfg_enable = 2'b11;
      tick();
      checks++;
      if (m_irq_valid !== 1'b1 || m_irq_index !== 5'd4) begin
         errors++;
         $display("FAIL mask_reenable valid=%b index=%0d (required 1 4)", m_irq_valid, m_irq_index);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      cfg_holdoff = 16'd50; m_irq_ready = 1'b1;
      irq_in = 2'b01; tick(); irq_in = '0; tick(); tick();
      m_irq_ready = 1'b0;
      irq_in = 2'b10; tick(); irq_in = '0; tick();
      checks++;
      if (m_irq_valid !== 1'b1 || m_irq_index !== 5'd5) begin
         errors++;
         $display("FAIL rst_pre valid=%b index=%0d (required 1 5)", m_irq_valid, m_irq_index);
      end
      rst = 1'b1; tick(); rst = 1'b0;
      checks++;
      if (m_irq_valid !== 1'b0 || m_irq_index !== 5'd0 || sts_pending !== 2'b00) begin
         errors++;
         $display("FAIL rst_mid valid=%b index=%0d pending=%b (required 0 0 00)",
                  m_irq_valid, m_irq_index, sts_pending);
      end
      cfg_holdoff = '0; m_irq_ready = 1'b1;
      irq_in = 2'b01; tick(); irq_in = '0; tick();
      checks++;
      if (m_irq_valid !== 1'b1 || m_irq_index !== 5'd4) begin
         errors++;
         $display("FAIL rst_timer_clear valid=%b index=%0d (required 1 4)", m_irq_valid, m_irq_index);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_merge();
      test_set_wins();
      test_holdoff();
      test_round_robin();
      test_masking();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
